// File: rtl/bj_pkg.sv
// Shared types and constants for the blackjack card dealer.
package bj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_LOAD,
    ST_EVAL
  } dealer_state_t;

  localparam logic [3:0]  CARD_EMPTY    = 4'hF;
  localparam logic [3:0]  CARD_MAX_CODE = 4'd12;
  localparam int unsigned NUM_SLOTS     = 4;

  // Fibonacci step, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/bj_lfsr16.sv
// 16-bit free-running Fibonacci LFSR used as the card source.
module bj_lfsr16
  import bj_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic [15:0] out
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/bj_card_dealer.sv
// Write-side controller for the 4-slot blackjack hand register: draws cards,
// loads them, reads back the total and tracks bust / hand-over status.
module bj_card_dealer
  import bj_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned BUST_LIMIT = 21,
  parameter int unsigned DEAL_INIT  = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       NEW_HAND,
  input  logic       HIT,
  input  logic       STAND,
  input  logic [4:0] CNT,
  output logic       LD,
  output logic [1:0] POS,
  output logic [3:0] D,
  output logic       HAND_CLR,
  output logic       BUSY,
  output logic       DONE,
  output logic       BUST,
  output logic       HAND_OVER,
  output logic [2:0] CARDS
);

  localparam logic [4:0] BUST_LIM  = 5'(BUST_LIMIT);
  localparam logic [2:0] DEAL_CNT  = 3'(DEAL_INIT);
  localparam logic [2:0] FULL_HAND = 3'(NUM_SLOTS);

  dealer_state_t state_q, state_d;
  logic [3:0]    card_q, card_d;
  logic [2:0]    cards_q, cards_d;
  logic [2:0]    pending_q, pending_d;
  logic          bust_q, bust_d;
  logic          over_q, over_d;
  logic          done_q, done_d;
  logic          ld;
  logic          hand_clr;
  logic          can_act;
  logic [15:0]   lfsr;
  logic [3:0]    candidate;
  logic [11:0]   lfsr_unused;

  bj_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK (CLK),
    .CLR (CLR),
    .out (lfsr)
  );

  assign candidate   = lfsr[3:0];
  assign lfsr_unused = lfsr[15:4];
  assign can_act     = !over_q && (cards_q != 3'd0);

  always_comb begin
    state_d   = state_q;
    card_d    = card_q;
    cards_d   = cards_q;
    pending_d = pending_q;
    bust_d    = bust_q;
    over_d    = over_q;
    done_d    = 1'b0;
    ld        = 1'b0;
    hand_clr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (NEW_HAND) begin
          state_d = ST_CLEAR;
        end else if (HIT && can_act) begin
          pending_d = 3'd1;
          state_d   = ST_DRAW;
        end else if (STAND && can_act) begin
          over_d = 1'b1;
          done_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        hand_clr  = 1'b1;
        cards_d   = '0;
        bust_d    = 1'b0;
        over_d    = 1'b0;
        pending_d = DEAL_CNT;
        state_d   = ST_DRAW;
      end

      // Codes 13..15 are rejected; keep sampling the free-running LFSR.
      ST_DRAW: begin
        if (candidate <= CARD_MAX_CODE) begin
          card_d  = candidate;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld        = 1'b1;
        cards_d   = cards_q + 3'd1;
        pending_d = pending_q - 3'd1;
        state_d   = ST_EVAL;
      end

      ST_EVAL: begin
        if (CNT > BUST_LIM) begin
          bust_d  = 1'b1;
          over_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if ((pending_q != 3'd0) && (cards_q != FULL_HAND)) begin
          state_d = ST_DRAW;
        end else begin
          over_d  = (cards_q == FULL_HAND);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      card_q    <= CARD_EMPTY;
      cards_q   <= '0;
      pending_q <= '0;
      bust_q    <= 1'b0;
      over_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      card_q    <= card_d;
      cards_q   <= cards_d;
      pending_q <= pending_d;
      bust_q    <= bust_d;
      over_q    <= over_d;
      done_q    <= done_d;
    end
  end

  assign LD        = ld;
  assign POS       = ld ? cards_q[1:0] : 2'd0;
  assign D         = ld ? card_q : 4'd0;
  assign HAND_CLR  = hand_clr;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign BUST      = bust_q;
  assign HAND_OVER = over_q;
  assign CARDS     = cards_q;

endmodule
